// File: rtl/gte_instr_sequencer_if.sv
// Command/status bundle between the COP2 front end and the GTE sequencer.
// The master side issues commands; the slave side is the sequencer.
interface gte_instr_sequencer_if;
  logic        i_run;
  logic [24:0] i_instr;
  logic        i_hold;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_illegal;
  logic        o_uvalid;
  logic [11:0] o_uaddr;
  logic [5:0]  o_step;
  logic [1:0]  o_vidx;
  logic [1:0]  o_matsel;
  logic [1:0]  o_vecsel;
  logic [24:0] o_instr;

  modport master (
    output i_run, i_instr, i_hold, i_abort,
    input  o_busy, o_done, o_illegal, o_uvalid, o_uaddr, o_step,
           o_vidx, o_matsel, o_vecsel, o_instr
  );

  modport slave (
    input  i_run, i_instr, i_hold, i_abort,
    output o_busy, o_done, o_illegal, o_uvalid, o_uaddr, o_step,
           o_vidx, o_matsel, o_vecsel, o_instr
  );
endinterface

// File: rtl/gte_instr_sequencer.sv
// GTE command sequencer: latches one COP2 command, walks its microcode steps
// and produces the vertex/matrix/vector selects until the command completes.
module gte_instr_sequencer #(
  parameter int EXTRA_CYCLES = 0,
  parameter bit TRIPLE_EN    = 1'b1
) (
  input logic i_clk,
  input logic i_rst,
  gte_instr_sequencer_if.slave bus
);

  localparam logic [5:0] OP_MVMVA = 6'h12;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic       legal;
    logic       triple;
    logic [5:0] base;
    logic [5:0] pass;
  } opInfo_t;

  // Triple ops report their full length (three passes plus epilogue) in base.
  function automatic opInfo_t decode(input logic [5:0] op);
    opInfo_t info;
    info       = '0;
    info.legal = 1'b1;
    case (op)
      6'h01: info.base = 6'd15;
      6'h06: info.base = 6'd8;
      6'h0C: info.base = 6'd6;
      6'h10: info.base = 6'd8;
      6'h11: info.base = 6'd8;
      6'h12: info.base = 6'd8;
      6'h13: info.base = 6'd19;
      6'h14: info.base = 6'd13;
      6'h1E: info.base = 6'd14;
      6'h1B: info.base = 6'd17;
      6'h1C: info.base = 6'd11;
      6'h28: info.base = 6'd5;
      6'h29: info.base = 6'd8;
      6'h2D: info.base = 6'd5;
      6'h2E: info.base = 6'd6;
      6'h3D: info.base = 6'd5;
      6'h3E: info.base = 6'd5;
      6'h30: begin info.triple = 1'b1; info.pass = 6'd7;  info.base = 6'd23; end
      6'h20: begin info.triple = 1'b1; info.pass = 6'd10; info.base = 6'd30; end
      6'h16: begin info.triple = 1'b1; info.pass = 6'd14; info.base = 6'd44; end
      6'h3F: begin info.triple = 1'b1; info.pass = 6'd13; info.base = 6'd39; end
      6'h2A: begin info.triple = 1'b1; info.pass = 6'd5;  info.base = 6'd17; end
      default: info.legal = 1'b0;
    endcase
    if (info.triple && !TRIPLE_EN) info.legal = 1'b0;
    return info;
  endfunction

  state_t      state;
  logic [5:0]  stepQ;
  logic [5:0]  lastStep;
  logic [5:0]  passLast;
  logic [5:0]  passCnt;
  logic [5:0]  opQ;
  logic [1:0]  vidxQ;
  logic [1:0]  vecselQ;
  logic [1:0]  matselQ;
  logic        tripleQ;
  logic        illegalQ;
  logic [24:0] instrQ;

  opInfo_t    info;
  logic       isLast;
  logic [1:0] vidxNext;
  logic [5:0] passNext;

  assign info   = decode(bus.i_instr[5:0]);
  assign isLast = (stepQ == lastStep);

  // Vertex index saturates at 2, so epilogue steps stay on the last vertex.
  always_comb begin
    vidxNext = vidxQ;
    passNext = passCnt + 6'd1;
    if (passCnt == passLast) begin
      passNext = '0;
      if (vidxQ != 2'd2) vidxNext = vidxQ + 2'd1;
    end
  end

  // Single FSM; leaving RUN clears the select outputs but keeps the command word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      stepQ    <= '0;
      lastStep <= '0;
      passLast <= '0;
      passCnt  <= '0;
      opQ      <= '0;
      vidxQ    <= '0;
      vecselQ  <= '0;
      matselQ  <= '0;
      tripleQ  <= 1'b0;
      illegalQ <= 1'b0;
      instrQ   <= '0;
    end else begin
      illegalQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_run && !bus.i_abort) begin
            if (info.legal) begin
              state    <= RUN;
              instrQ   <= bus.i_instr;
              opQ      <= bus.i_instr[5:0];
              stepQ    <= '0;
              lastStep <= info.base + 6'(EXTRA_CYCLES) - 6'd1;
              passLast <= info.pass - 6'd1;
              passCnt  <= '0;
              vidxQ    <= '0;
              matselQ  <= bus.i_instr[18:17];
              vecselQ  <= (bus.i_instr[5:0] == OP_MVMVA) ? bus.i_instr[16:15] : 2'd0;
              tripleQ  <= info.triple;
            end else begin
              illegalQ <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.i_abort || (!bus.i_hold && isLast)) begin
            state   <= IDLE;
            stepQ   <= '0;
            opQ     <= '0;
            vidxQ   <= '0;
            vecselQ <= '0;
            matselQ <= '0;
          end else if (!bus.i_hold) begin
            stepQ <= stepQ + 6'd1;
            if (tripleQ) begin
              vidxQ   <= vidxNext;
              vecselQ <= vidxNext;
              passCnt <= passNext;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy    = (state == RUN);
  assign bus.o_done    = (state == RUN) && !bus.i_hold && !bus.i_abort && isLast;
  assign bus.o_illegal = illegalQ;
  assign bus.o_uvalid  = (state == RUN) && !bus.i_hold;
  assign bus.o_uaddr   = {opQ, stepQ};
  assign bus.o_step    = stepQ;
  assign bus.o_vidx    = vidxQ;
  assign bus.o_matsel  = matselQ;
  assign bus.o_vecsel  = vecselQ;
  assign bus.o_instr   = instrQ;

endmodule

// File: doc/gte_instr_sequencer.md
Name: gte_instr_sequencer

Overview:
- Sequences the GTE compute path for one GTE command at a time.
- Accepts a 25-bit command word from the COP2 interface and latches it.
- Steps a per-opcode cycle counter and emits a microcode address, vertex index and matrix/vector selects that drive the sel1/sel2/sel3 mux control and writeback.
- Holds o_busy so the CPU stalls on COP2 accesses until the command completes.

Parameters:
EXTRA_CYCLES, 0, extra busy cycles appended to every opcode's count N (pipeline tail).
TRIPLE_EN, 1, 1 = the triple ops RTPT/NCT/NCDT/NCCT/DPCT are supported; 0 = they are treated as illegal.

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous active-high reset.
i_run  in  1  command strobe, sampled only in IDLE.
i_instr  in  25  command: [19] sf, [18:17] mx, [16:15] v, [14:13] cv, [10] lm, [5:0] opcode.
i_hold  in  1  freeze sequencing this cycle (writeback/register-port stall).
i_abort  in  1  cancel the current command.
o_busy  out  1  command in progress.
o_done  out  1  one-cycle pulse on the final step.
o_illegal  out  1  one-cycle pulse for an unsupported opcode.
o_uvalid  out  1  the current step is issued this cycle.
o_uaddr  out  12  {latched opcode, step[5:0]}.
o_step  out  6  current step index.
o_vidx  out  2  vertex pass 0..2.
o_matsel  out  2  latched mx.
o_vecsel  out  2  MVMVA: latched v; triple ops: o_vidx; other ops: 0.
o_instr  out  25  latched command, stable while busy.

Behaviour:
- Reset (i_rst at an edge, including mid-command): state IDLE; every output 0.
- States: IDLE, RUN. An unsupported opcode never enters RUN.
- IDLE with i_run=1 and i_abort=0, supported opcode:
  - latch i_instr, step=0, go to RUN.
  - o_busy rises the next cycle.
- IDLE with i_run=1 and unsupported opcode:
  - stay IDLE; o_illegal=1 for exactly the next cycle.
  - o_busy and o_done stay 0.
- IDLE with i_run=1 and i_abort=1: command ignored, no pulses.
- Cycle counts, N = table value + EXTRA_CYCLES:
  - RTPS 15, NCLIP 8, OP 6, DPCS 8, INTPL 8, MVMVA 8, NCDS 19, CDP 13, NCS 14, NCCS 17, CC 11, SQR 5, DCPL 8, AVSZ3 5, AVSZ4 6, GPF 5, GPL 5.
  - Triple ops, pass length P and epilogue E: RTPT P=7 E=2 (23); NCT P=10 E=0 (30); NCDT P=14 E=2 (44); NCCT P=13 E=0 (39); DPCT P=5 E=2 (17).
  - Any other opcode is illegal.
- RUN:
  - o_busy=1.
  - o_uvalid = ~i_hold (combinational).
  - If i_hold=0, step advances by 1 per cycle. If i_hold=1, step and every registered output freeze.
- Completion:
  - o_done=1 in the cycle where step==N-1 and i_hold=0.
  - Next cycle: IDLE, o_busy=0.
  - An i_run in the done cycle is ignored; it is accepted from the following cycle.
- o_vidx:
  - triple ops: min(2, step/P). Epilogue steps keep 2.
  - all other ops: 0.
- i_abort in RUN: next cycle IDLE, o_busy=0, no o_done. i_abort takes priority over i_hold and over completion.
- i_run while RUN: ignored, no queueing; the CPU is stalled by o_busy.
- o_uaddr, o_step, o_vidx, o_vecsel, o_matsel:
  - valid only while o_busy.
  - forced to 0 in IDLE.
- o_instr holds its last value in IDLE.
- The step counter never wraps: N ≤ 63 is guaranteed for EXTRA_CYCLES ≤ 19. Larger EXTRA_CYCLES is unsupported.

Test Plan:
1. Reset, then RTPS (opcode 0x01), hold=0, run at cycle 0 → o_busy high at cycles 1..15; o_uaddr 0x040..0x04E; o_done at cycle 15; IDLE at cycle 16.
2. RTPT (0x30) → busy 23 cycles; o_vidx 0 for steps 0–6, 1 for steps 7–13, 2 for steps 14–22; o_vecsel tracks o_vidx; done at step 22.
3. MVMVA with mx=2, v=3, i_hold high for steps 3–5 → o_matsel=2, o_vecsel=3; o_uvalid low and step frozen at 3 for 3 cycles; done delayed to cycle 11 (8+3).
4. i_abort at step 10 of NCDS → o_busy drops next cycle, no o_done; a following SQR runs 5 cycles normally.
5. Opcode 0x00, then 0x30 with TRIPLE_EN=0 → o_illegal single pulse each time, o_busy stays 0; i_run during RUN of OP is ignored (done at cycle 6, one command only).
6. i_rst asserted at step 4 of NCCT → all outputs 0 the next cycle; i_run on the same cycle as o_done is not accepted.
